// File: rtl/if_fetch.sv
// Instruction fetch stage: one-entry output buffer feeding IF/ID, single outstanding imem read.
// Optional performance counters are enabled with `define IF_FETCH_PERF_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] pcAdd4IF,
  output logic [31:0] instructionIF
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] bubbleCount
`endif
);

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    DROP
  } state_t;

  state_t      state, stateNext;
  logic [31:0] pc, pcNext;
  logic [31:0] reqAddr, reqAddrNext;
  logic        holdValid, holdValidNext;
  logic [31:0] holdInstr, holdInstrNext;
  logic [31:0] holdPcAdd4, holdPcAdd4Next;
  logic        canAccept;
  logic        consume;
  logic        capture;
  logic [31:0] captureAddr;

  always_comb begin
    canAccept      = !holdValid || !stall;
    consume        = holdValid && !stall;
    imemReq        = 1'b0;
    imemAddr       = pc;
    capture        = 1'b0;
    captureAddr    = pc;
    stateNext      = state;
    pcNext         = pc;
    reqAddrNext    = reqAddr;
    holdValidNext  = holdValid && !consume;
    holdInstrNext  = holdInstr;
    holdPcAdd4Next = holdPcAdd4;

    unique case (state)
      ISSUE: begin
        imemReq = canAccept && !branchTaken && !reset;
        if (imemReq) begin
          if (imemReady) begin
            capture = 1'b1;
          end else begin
            reqAddrNext = pc;
            stateNext   = WAIT;
          end
        end
      end
      WAIT: begin
        // The buffer was drained when this request was issued, so a capture here never overwrites.
        imemReq     = !reset;
        imemAddr    = reqAddr;
        captureAddr = reqAddr;
        if (imemReady) begin
          capture   = !branchTaken;
          stateNext = ISSUE;
        end else if (branchTaken) begin
          stateNext = DROP;
        end
      end
      DROP: begin
        imemReq  = !reset;
        imemAddr = reqAddr;
        if (imemReady) stateNext = ISSUE;
      end
      default: stateNext = ISSUE;
    endcase

    if (capture) begin
      holdValidNext  = 1'b1;
      holdInstrNext  = imemData;
      holdPcAdd4Next = captureAddr + 32'd4;
      pcNext         = captureAddr + 32'd4;
    end
    // A redirect flushes the buffer and wins over stall and any same-cycle capture.
    if (branchTaken) begin
      holdValidNext = 1'b0;
      pcNext        = branchTarget;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ISSUE;
      pc         <= RESET_PC;
      reqAddr    <= '0;
      holdValid  <= 1'b0;
      holdInstr  <= '0;
      holdPcAdd4 <= '0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      reqAddr    <= reqAddrNext;
      holdValid  <= holdValidNext;
      holdInstr  <= holdInstrNext;
      holdPcAdd4 <= holdPcAdd4Next;
    end
  end

  always_comb begin
    pcAdd4IF      = holdValid ? holdPcAdd4 : '0;
    instructionIF = holdValid ? holdInstr : '0;
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchCount  <= '0;
      bubbleCount <= '0;
    end else begin
      if (capture) fetchCount <= fetchCount + 32'd1;
      if (!stall && !holdValid) bubbleCount <= bubbleCount + 32'd1;
    end
  end
`endif

endmodule
